// File: rtl/usb_cmd_rx_if.sv
// usb_cmd_rx_if: FT245 read-FIFO port plus status-byte valid/ready port of the command decoder
//
// Signals (named from the decoder's point of view):
//   rden_o       FIFO read request, data returns the next cycle
//   rddata_i     FIFO read data
//   rdempty_i    FIFO empty flag
//   ack_valid_o  status byte available
//   ack_data_o   status byte
//   ack_ready_i  consumer accepts the status byte
// Modports: master = decoder side, slave = FT245 / write-path side.
interface usb_cmd_rx_if;
   logic       rden_o;
   logic [7:0] rddata_i;
   logic       rdempty_i;
   logic       ack_valid_o;
   logic [7:0] ack_data_o;
   logic       ack_ready_i;
   modport master (
      output rden_o, ack_valid_o, ack_data_o,
      input  rddata_i, rdempty_i, ack_ready_i
   );
   modport slave (
      input  rden_o, ack_valid_o, ack_data_o,
      output rddata_i, rdempty_i, ack_ready_i
   );
endinterface

// File: rtl/usb_cmd_rx.sv
// usb_cmd_rx: frames 5-byte host commands (SYNC CMD DH DL CSUM) from the FT245 read FIFO into a 16-bit register bank
//
// Ports:
//   clk_i      system clock (40 MHz domain shared with the ft245 user side)
//   rst_n      synchronous active-low reset
//   bus        FIFO read port and status-byte valid/ready port (usb_cmd_rx_if.master)
//   regs_o     flattened register bank, reg k at [16k+15:16k]
//   wr_stb_o   one-cycle pulse on each register write
//   wr_addr_o  address of the most recent write
//   err_cnt_o  saturating count of rejected frames (checksum, bad command, timeout)
module usb_cmd_rx #(
   parameter int unsigned          N_REGS    = 8,
   parameter int unsigned          REG_WIDTH = 16,
   parameter logic [7:0]           SYNC_BYTE = 8'hA5,
   parameter int unsigned          TIMEOUT   = 4000000,
   parameter logic [N_REGS*16-1:0] REG_RESET = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_n,
   usb_cmd_rx_if.master              bus,
   output logic [N_REGS*16-1:0]      regs_o,
   output logic                      wr_stb_o,
   output logic [$clog2(N_REGS)-1:0] wr_addr_o,
   output logic [7:0]                err_cnt_o
);
   localparam int AW = $clog2(N_REGS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [7:0] ST_OK   = 8'h5A;
   localparam logic [7:0] ST_CSUM = 8'hE1;
   localparam logic [7:0] ST_CMD  = 8'hE2;
   localparam logic [7:0] ST_TMO  = 8'hE3;
   typedef enum logic [2:0] {S_HUNT, S_CMD, S_DH, S_DL, S_CSUM, S_EXEC, S_RESP} state_e;
   state_e                state_q;
   logic                  inflight_q;
   logic [7:0]            cmd_q, dh_q, dl_q, csum_q;
   logic [TW-1:0]         cnt_q, cnt_d;
   logic [N_REGS*16-1:0]  regs_q;
   logic                  wr_stb_q;
   logic [AW-1:0]         wr_addr_q;
   logic                  ack_valid_q;
   logic [7:0]            ack_data_q;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic                  in_frame, tmo, rden, csum_ok, cmd_ok;
   logic [REG_WIDTH-1:0]  word;
   assign in_frame = state_q inside {S_CMD, S_DH, S_DL, S_CSUM};
   // A byte landing on the last idle cycle wins over the timeout.
   assign tmo      = in_frame && !inflight_q && cnt_q == TW'(TIMEOUT - 1);
   // The timeout cycle also blocks a new read, so a byte popped then is never stranded in RESP.
   // Gating with rst_n keeps the FIFO untouched while the decoder is held in reset.
   assign rden     = rst_n && !bus.rdempty_i && (state_q == S_HUNT || in_frame) && !inflight_q && !tmo;
   assign cnt_d    = (inflight_q || !in_frame) ? '0 : cnt_q + TW'(1);
   assign err_cnt_d = err_cnt_q + {7'd0, err_cnt_q != 8'hFF};
   assign csum_ok  = (cmd_q ^ dh_q ^ dl_q) == csum_q;
   // N_REGS <= 16, so this also rejects any CMD with reserved high bits set.
   assign cmd_ok   = cmd_q < 8'(N_REGS);
   assign word     = {dh_q, dl_q};
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q     <= S_HUNT;
         inflight_q  <= 1'b0;
         cnt_q       <= '0;
         cmd_q       <= '0;
         dh_q        <= '0;
         dl_q        <= '0;
         csum_q      <= '0;
         regs_q      <= REG_RESET;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         ack_valid_q <= 1'b0;
         ack_data_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         inflight_q <= rden;
         cnt_q      <= cnt_d;
         wr_stb_q   <= 1'b0;
         case (state_q)
            S_HUNT:
               if (inflight_q && bus.rddata_i == SYNC_BYTE) state_q <= S_CMD;
            S_CMD, S_DH, S_DL, S_CSUM:
               if (inflight_q) begin
                  cmd_q   <= state_q == S_CMD  ? bus.rddata_i : cmd_q;
                  dh_q    <= state_q == S_DH   ? bus.rddata_i : dh_q;
                  dl_q    <= state_q == S_DL   ? bus.rddata_i : dl_q;
                  csum_q  <= state_q == S_CSUM ? bus.rddata_i : csum_q;
                  state_q <= state_e'(state_q + 3'd1);
               end else if (tmo) begin
                  ack_valid_q <= 1'b1;
                  ack_data_q  <= ST_TMO;
                  err_cnt_q   <= err_cnt_d;
                  state_q     <= S_RESP;
               end
            S_EXEC: begin
               ack_valid_q <= 1'b1;
               state_q     <= S_RESP;
               if (!csum_ok) begin
                  ack_data_q <= ST_CSUM;
                  err_cnt_q  <= err_cnt_d;
               end else if (!cmd_ok) begin
                  ack_data_q <= ST_CMD;
                  err_cnt_q  <= err_cnt_d;
               end else begin
                  ack_data_q <= ST_OK;
                  wr_stb_q   <= 1'b1;
                  wr_addr_q  <= cmd_q[AW-1:0];
                  for (int k = 0; k < N_REGS; k++)
                     if (cmd_q == 8'(k)) regs_q[16*k +: 16] <= word;
               end
            end
            S_RESP:
               if (bus.ack_ready_i) begin
                  ack_valid_q <= 1'b0;
                  state_q     <= S_HUNT;
               end
            default: state_q <= S_HUNT;
         endcase
      end
   end
   assign bus.rden_o      = rden;
   assign bus.ack_valid_o = ack_valid_q;
   assign bus.ack_data_o  = ack_data_q;
   assign regs_o          = regs_q;
   assign wr_stb_o        = wr_stb_q;
   assign wr_addr_o       = wr_addr_q;
   assign err_cnt_o       = err_cnt_q;
endmodule
